// File: rtl/div_radix2_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed/unsigned,
// valid/ready request side and a held result until the consumer accepts it.
module div_radix2_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] Z_i,
  input  logic [WIDTH-1:0] D_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] s_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] z_orig;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] s_fix;
  logic [WIDTH-1:0] z_abs;
  logic [WIDTH-1:0] d_abs;

  always_comb begin
    z_abs   = (div_signed_i && Z_i[WIDTH-1]) ? -Z_i : Z_i;
    d_abs   = (div_signed_i && D_i[WIDTH-1]) ? -D_i : D_i;
    rem_sh  = {rem, dvd[WIDTH-1]};
    ge      = rem_sh >= {1'b0, dsr};
    // Remainder stays below |D|, so the subtraction fits in WIDTH bits whenever it is taken.
    rem_sub = rem_sh[WIDTH-1:0] - dsr;
    rem_nx  = ge ? rem_sub : rem_sh[WIDTH-1:0];
    q_raw   = {dvd[WIDTH-2:0], ge};
    q_fix   = neg_q ? -q_raw : q_raw;
    s_fix   = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_ready <= 1'b1;
      res_valid <= 1'b0;
      q_o       <= '0;
      s_o       <= '0;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      z_orig    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_valid && div_ready) begin
            state     <= CALC;
            div_ready <= 1'b0;
            dvd       <= z_abs;
            dsr       <= d_abs;
            rem       <= '0;
            cnt       <= '0;
            z_orig    <= Z_i;
            neg_q     <= div_signed_i & (Z_i[WIDTH-1] ^ D_i[WIDTH-1]);
            neg_r     <= div_signed_i & Z_i[WIDTH-1];
            div_zero  <= (D_i == '0);
          end
        end
        CALC: begin
          dvd <= q_raw;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            q_o       <= div_zero ? '1 : q_fix;
            s_o       <= div_zero ? z_orig : s_fix;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            div_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          div_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2_iter.sv
// Bench for div_radix2_iter: directed cases plus random pairs against a
// behavioural reference, results checked through a scoreboard queue.
module tb_div_radix2_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed_i;
  logic [31:0] Z_i;
  logic [31:0] D_i;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] q_o;
  logic [31:0] s_o;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] sb_q[$];

  div_radix2_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed_i(div_signed_i),
    .Z_i(Z_i), .D_i(D_i),
    .res_valid(res_valid), .res_ready(res_ready),
    .q_o(q_o), .s_o(s_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] z, input logic [31:0] d, input logic sgn);
    longint a, b;
    logic [31:0] q, s;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      s = z;
    end else if (sgn) begin
      a = longint'($signed(z));
      b = longint'($signed(d));
      q = 32'(a / b);
      s = 32'(a % b);
    end else begin
      q = z / d;
      s = z % d;
    end
    return {q, s};
  endfunction

  // Waits (bounded) for div_ready, then holds one request over the accept edge.
  task automatic send(input logic [31:0] z, input logic [31:0] d, input logic sgn);
    int unsigned n = 0;
    @(negedge clk);
    while (!div_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) chk("ready_timeout", 32'(div_ready), 32'd1);
    Z_i = z; D_i = d; div_signed_i = sgn; div_valid = 1'b1;
    sb_q.push_back(ref_div(z, d, sgn));
    @(posedge clk);
    #1 div_valid = 1'b0;
  endtask

  // Called #1 after the accept edge: measures latency and compares the result.
  task automatic collect(input string tag, input bit ack);
    int unsigned n = 0;
    int unsigned rdy_hi = 0;
    logic [63:0] e;
    while (!res_valid && n < 40) begin
      if (div_ready) rdy_hi++;
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, n, 32'd32);
    chk({tag, "_rdy_busy"}, rdy_hi, 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_q"}, q_o, e[63:32]);
      chk({tag, "_s"}, s_o, e[31:0]);
    end
    if (ack) begin
      @(negedge clk) res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      chk({tag, "_vld_drop"}, 32'(res_valid), 32'd0);
      chk({tag, "_rdy_back"}, 32'(div_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] hq, hs, z, d;
    logic        sg;
    rst = 1'b1; div_valid = 1'b0; div_signed_i = 1'b0;
    Z_i = '0; D_i = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(div_ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_q", q_o, 32'd0);
    chk("rst_s", s_o, 32'd0);

    send(32'd100, 32'd7, 1'b0);          collect("u100_7", 1'b1);
    chk("u100_7_q_kept", q_o, 32'd14);
    chk("u100_7_s_kept", s_o, 32'd2);
    send(32'hFFFF_FFF9, 32'd2, 1'b1);     collect("s_m7_2", 1'b1);
    send(32'hFFFF_FFF9, 32'd2, 1'b0);     collect("u_m7_2", 1'b1);
    send(32'd5, 32'd0, 1'b1);             collect("s_dz", 1'b1);
    send(32'd5, 32'd0, 1'b0);             collect("u_dz", 1'b1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); collect("s_ovf", 1'b1);
    chk("const_q_m7", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1) == {32'hFFFF_FFFD, 32'hFFFF_FFFF} ? 32'd1 : 32'd0, 32'd1);

    // Back-pressure: result held while a new request is offered.
    send(32'd1000, 32'd33, 1'b0);
    collect("bp", 1'b0);
    hq = q_o; hs = s_o;
    @(negedge clk);
    Z_i = 32'd100; D_i = 32'd7; div_signed_i = 1'b0; div_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_q_hold", q_o, 32'd30);
      chk("bp_s_hold", s_o, 32'd10);
      chk("bp_vld_hold", 32'(res_valid), 32'd1);
      chk("bp_no_accept", 32'(div_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("bp_idle_rdy", 32'(div_ready), 32'd1);
    chk("bp_idle_vld", 32'(res_valid), 32'd0);
    chk("bp_q_after", q_o, hq);
    chk("bp_s_after", s_o, hs);
    sb_q.push_back(ref_div(32'd100, 32'd7, 1'b0));
    @(posedge clk);
    #1 div_valid = 1'b0;
    chk("bp_accepted", 32'(div_ready), 32'd0);
    collect("bp_next", 1'b1);

    // Reset during CALC discards the in-flight result.
    send(32'd12345, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb_q.pop_back());
    chk("midrst_vld", 32'(res_valid), 32'd0);
    chk("midrst_rdy", 32'(div_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1 chk("midrst_no_res", 32'(res_valid), 32'd0);
    send(32'hFFFF_FFFF, 32'd1, 1'b0);     collect("u_max_1", 1'b1);

    for (int unsigned i = 0; i < 200; i++) begin
      z  = $urandom;
      d  = $urandom;
      sg = 1'($urandom_range(1, 0));
      if (i % 4 == 1) d = d >> $urandom_range(31, 0);
      if (d == 32'd0) d = 32'd3;
      send(z, d, sg);
      collect("rand", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
